// File: rtl/control_unit_team1.sv
// Hardwired control unit for the team1 basic computer.
// It keeps the sequence counter, the indirect bit and the halt flag. All datapath
// strobes are combinational decodes of that state plus the instruction and status inputs.
module control_unit_team1 (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [15:0] out_IR,
  input  logic [15:0] out_AC,
  input  logic        out_E,
  input  logic        Zero_DR,
  input  logic        FGI,
  output logic [2:0]  S,
  output logic        LD_PC,
  output logic        LD_AR,
  output logic        LD_AC,
  output logic        LD_DR,
  output logic        LD_IR,
  output logic        LD_OUTR,
  output logic        LD_TR,
  output logic        INR_PC,
  output logic        INR_AR,
  output logic        INR_AC,
  output logic        INR_DR,
  output logic        INR_TR,
  output logic        RST_PC,
  output logic        RST_AR,
  output logic        RST_AC,
  output logic        RST_DR,
  output logic        RST_TR,
  output logic        AND,
  output logic        ADD,
  output logic        LDA,
  output logic        COM,
  output logic        SHL,
  output logic        SHR,
  output logic        INPR_C,
  output logic        CLE,
  output logic        CME,
  output logic        Read,
  output logic        Write,
  output logic        halted,
  output logic [2:0]  sc
);

  logic [2:0] sc_r;
  logic [2:0] sc_next_s;
  logic       i_r;
  logic       i_next_s;
  logic       halt_r;
  logic       halt_next_s;
  logic [2:0] d_s;
  logic       d7_s;
  logic       hlt_acts_s;

  assign d_s  = out_IR[14:12];
  assign d7_s = (d_s == 3'd7);
  // HLT only acts when no higher-priority register-reference bit is set
  assign hlt_acts_s = (out_IR[11:1] == 11'd0) && out_IR[0];

  assign halted = halt_r;
  assign sc     = sc_r;

  // State register: sequence counter, indirect bit and halt flag
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sc_r   <= 3'd0;
      i_r    <= 1'b0;
      halt_r <= 1'b0;
    end else begin
      sc_r   <= sc_next_s;
      i_r    <= i_next_s;
      halt_r <= halt_next_s;
    end
  end

  // Next-state logic: advance or wrap the sequence counter, capture I, latch HALT
  always_comb begin
    sc_next_s   = sc_r;
    i_next_s    = i_r;
    halt_next_s = halt_r;
    if (halt_r) begin
      sc_next_s = sc_r;
    end else begin
      case (sc_r)
        3'd0, 3'd1: sc_next_s = sc_r + 3'd1;
        3'd2: begin
          sc_next_s = 3'd3;
          i_next_s  = out_IR[15];
        end
        3'd3: begin
          if (d7_s) begin
            sc_next_s = 3'd0;
            if (!i_r && hlt_acts_s) begin
              halt_next_s = 1'b1;
            end else begin
              halt_next_s = 1'b0;
            end
          end else begin
            sc_next_s = 3'd4;
          end
        end
        3'd4: begin
          if ((d_s == 3'd3) || (d_s == 3'd4)) begin
            sc_next_s = 3'd0;
          end else begin
            sc_next_s = 3'd5;
          end
        end
        3'd5: begin
          if (d_s == 3'd6) begin
            sc_next_s = 3'd6;
          end else begin
            sc_next_s = 3'd0;
          end
        end
        3'd6:    sc_next_s = 3'd0;
        default: sc_next_s = 3'd0;  // illegal step value recovers to T0
      endcase
    end
  end

  // Output decode: strobes for the current step, all forced low in reset or halt
  always_comb begin
    S = 3'd0;
    LD_PC = 1'b0; LD_AR = 1'b0; LD_AC = 1'b0; LD_DR = 1'b0;
    LD_IR = 1'b0; LD_OUTR = 1'b0; LD_TR = 1'b0;
    INR_PC = 1'b0; INR_AR = 1'b0; INR_AC = 1'b0; INR_DR = 1'b0; INR_TR = 1'b0;
    RST_PC = 1'b0; RST_AR = 1'b0; RST_AC = 1'b0; RST_DR = 1'b0; RST_TR = 1'b0;
    AND = 1'b0; ADD = 1'b0; LDA = 1'b0; COM = 1'b0; SHL = 1'b0; SHR = 1'b0;
    INPR_C = 1'b0; CLE = 1'b0; CME = 1'b0;
    Write = 1'b0;
    if (RST_N && !halt_r) begin
      case (sc_r)
        3'd0: begin S = 3'd2; LD_AR = 1'b1; end
        3'd1: begin S = 3'd7; LD_IR = 1'b1; INR_PC = 1'b1; end
        3'd2: begin S = 3'd5; LD_AR = 1'b1; end
        3'd3: begin
          if (d7_s && !i_r) begin
            if      (out_IR[11]) RST_AC = 1'b1;
            else if (out_IR[10]) CLE = 1'b1;
            else if (out_IR[9])  begin COM = 1'b1; LD_AC = 1'b1; end
            else if (out_IR[8])  CME = 1'b1;
            else if (out_IR[7])  begin SHR = 1'b1; LD_AC = 1'b1; end
            else if (out_IR[6])  begin SHL = 1'b1; LD_AC = 1'b1; end
            else if (out_IR[5])  INR_AC = 1'b1;
            else if (out_IR[4])  INR_PC = ~out_AC[15];
            else if (out_IR[3])  INR_PC = out_AC[15];
            else if (out_IR[2])  INR_PC = (out_AC == 16'd0);
            else if (out_IR[1])  INR_PC = ~out_E;
            else                 INR_PC = 1'b0;  // HLT or NOP: no strobe
          end else if (d7_s) begin
            if      (out_IR[11]) begin INPR_C = 1'b1; LD_AC = 1'b1; end
            else if (out_IR[10]) begin S = 3'd4; LD_OUTR = 1'b1; end
            else if (out_IR[9])  INR_PC = FGI;
            else                 INR_PC = 1'b0;
          end else if (i_r) begin
            S = 3'd7; LD_AR = 1'b1;  // indirect: fetch effective address
          end else begin
            S = 3'd0;
          end
        end
        3'd4: begin
          case (d_s)
            3'd0, 3'd1, 3'd2, 3'd6: begin S = 3'd7; LD_DR = 1'b1; end
            3'd3: begin S = 3'd4; Write = 1'b1; end
            3'd4: begin S = 3'd1; LD_PC = 1'b1; end
            3'd5: begin S = 3'd2; Write = 1'b1; INR_AR = 1'b1; end
            default: S = 3'd0;
          endcase
        end
        3'd5: begin
          case (d_s)
            3'd0: begin AND = 1'b1; LD_AC = 1'b1; end
            3'd1: begin ADD = 1'b1; LD_AC = 1'b1; end
            3'd2: begin LDA = 1'b1; LD_AC = 1'b1; end
            3'd5: begin S = 3'd1; LD_PC = 1'b1; end
            3'd6: INR_DR = 1'b1;
            default: S = 3'd0;
          endcase
        end
        3'd6: begin
          if (d_s == 3'd6) begin
            S = 3'd3; Write = 1'b1; INR_PC = Zero_DR;
          end else begin
            S = 3'd0;
          end
        end
        default: S = 3'd0;
      endcase
    end else begin
      S = 3'd0;
    end
    Read = (S == 3'd7);
  end

endmodule

// File: tb/tb_control_unit_team1.sv
// Table-driven bench for control_unit_team1: per-cycle vectors of instruction and
// status inputs with the expected step counter and packed strobe word.
module tb_control_unit_team1;

  logic clk, RST_N;
  logic [15:0] out_IR, out_AC;
  logic out_E, Zero_DR, FGI;
  logic [2:0] S, sc;
  logic LD_PC, LD_AR, LD_AC, LD_DR, LD_IR, LD_OUTR, LD_TR;
  logic INR_PC, INR_AR, INR_AC, INR_DR, INR_TR;
  logic RST_PC, RST_AR, RST_AC, RST_DR, RST_TR;
  logic AND, ADD, LDA, COM, SHL, SHR, INPR_C, CLE, CME, Read, Write, halted;

  control_unit_team1 dut (
    .clk(clk), .RST_N(RST_N), .out_IR(out_IR), .out_AC(out_AC), .out_E(out_E),
    .Zero_DR(Zero_DR), .FGI(FGI), .S(S),
    .LD_PC(LD_PC), .LD_AR(LD_AR), .LD_AC(LD_AC), .LD_DR(LD_DR), .LD_IR(LD_IR),
    .LD_OUTR(LD_OUTR), .LD_TR(LD_TR),
    .INR_PC(INR_PC), .INR_AR(INR_AR), .INR_AC(INR_AC), .INR_DR(INR_DR), .INR_TR(INR_TR),
    .RST_PC(RST_PC), .RST_AR(RST_AR), .RST_AC(RST_AC), .RST_DR(RST_DR), .RST_TR(RST_TR),
    .AND(AND), .ADD(ADD), .LDA(LDA), .COM(COM), .SHL(SHL), .SHR(SHR), .INPR_C(INPR_C),
    .CLE(CLE), .CME(CME), .Read(Read), .Write(Write), .halted(halted), .sc(sc)
  );

  always #5 clk = ~clk;

  // packed strobe word bit masks
  localparam logic [31:0] HALTED = 32'h0000_0001, WR = 32'h0000_0002;
  localparam logic [31:0] C_CME = 32'h0000_0008, C_CLE = 32'h0000_0010, C_INPR = 32'h0000_0020;
  localparam logic [31:0] C_SHR = 32'h0000_0040, C_SHL = 32'h0000_0080, C_COM = 32'h0000_0100;
  localparam logic [31:0] C_LDA = 32'h0000_0200, C_ADD = 32'h0000_0400, C_AND = 32'h0000_0800;
  localparam logic [31:0] R_AC = 32'h0000_4000;
  localparam logic [31:0] I_DR = 32'h0004_0000, I_AC = 32'h0008_0000, I_AR = 32'h0010_0000;
  localparam logic [31:0] I_PC = 32'h0020_0000, L_OUTR = 32'h0080_0000, L_IR = 32'h0100_0000;
  localparam logic [31:0] L_DR = 32'h0200_0000, L_AC = 32'h0400_0000, L_AR = 32'h0800_0000;
  localparam logic [31:0] L_PC = 32'h1000_0000;
  localparam logic [31:0] S_AR = 32'h2000_0000, S_PC = 32'h4000_0000, S_DR = 32'h6000_0000;
  localparam logic [31:0] S_AC = 32'h8000_0000, S_IR = 32'hA000_0000;
  localparam logic [31:0] S_MEM = 32'hE000_0004;  // bus = memory, Read included
  localparam logic [31:0] F0 = S_PC | L_AR;
  localparam logic [31:0] F1 = S_MEM | L_IR | I_PC;
  localparam logic [31:0] F2 = S_IR | L_AR;
  localparam logic [31:0] NONE = 32'h0000_0000;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] ac;
    logic        e;
    logic        zdr;
    logic        fgi;
    logic [2:0]  exp_sc;
    logic [31:0] exp_ctl;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pack_ctl();
    return {S, LD_PC, LD_AR, LD_AC, LD_DR, LD_IR, LD_OUTR, LD_TR,
            INR_PC, INR_AR, INR_AC, INR_DR, INR_TR,
            RST_PC, RST_AR, RST_AC, RST_DR, RST_TR,
            AND, ADD, LDA, COM, SHL, SHR, INPR_C, CLE, CME, Read, Write, halted};
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h required %h", name, row, got, exp);
    end
  endtask

  // one instruction = fetch rows T0..T2 plus the listed step rows up to n-1
  task automatic add_inst(input logic [15:0] ir, input logic [15:0] ac, input logic e,
                          input logic zdr, input logic fgi, input int n,
                          input logic [31:0] x3, input logic [31:0] x4,
                          input logic [31:0] x5, input logic [31:0] x6);
    logic [31:0] exp_t [7];
    exp_t = '{F0, F1, F2, x3, x4, x5, x6};
    for (int t = 0; t < n; t++) begin
      vec_t v;
      v.ir = ir; v.ac = ac; v.e = e; v.zdr = zdr; v.fgi = fgi;
      v.exp_sc = 3'(t);
      v.exp_ctl = exp_t[t];
      vq.push_back(v);
    end
  endtask

  task automatic run_row(input vec_t v, input int row);
    out_IR = v.ir; out_AC = v.ac; out_E = v.e; Zero_DR = v.zdr; FGI = v.fgi;
    #1;
    check("sc", row, {29'd0, sc}, {29'd0, v.exp_sc});
    check("ctl", row, pack_ctl(), v.exp_ctl);
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; RST_N = 1'b0;
    out_IR = 16'h0000; out_AC = 16'h0000; out_E = 1'b0; Zero_DR = 1'b0; FGI = 1'b0;

    // memory reference
    add_inst(16'h2005, 16'h0000, 1'b0, 1'b0, 1'b0, 6, NONE, S_MEM | L_DR, C_LDA | L_AC, NONE);
    add_inst(16'h9006, 16'h0004, 1'b0, 1'b0, 1'b0, 6, S_MEM | L_AR, S_MEM | L_DR, C_ADD | L_AC, NONE);
    add_inst(16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0, 6, NONE, S_MEM | L_DR, C_AND | L_AC, NONE);
    add_inst(16'h3004, 16'h0000, 1'b0, 1'b0, 1'b0, 5, NONE, S_AC | WR, NONE, NONE);
    add_inst(16'hC020, 16'h0000, 1'b0, 1'b0, 1'b0, 5, S_MEM | L_AR, S_AR | L_PC, NONE, NONE);
    add_inst(16'h500A, 16'h0000, 1'b0, 1'b0, 1'b0, 6, NONE, S_PC | WR | I_AR, S_AR | L_PC, NONE);
    add_inst(16'h6008, 16'h0000, 1'b0, 1'b1, 1'b0, 7, NONE, S_MEM | L_DR, I_DR, S_DR | WR | I_PC);
    add_inst(16'h6008, 16'h0000, 1'b0, 1'b0, 1'b0, 7, NONE, S_MEM | L_DR, I_DR, S_DR | WR);
    // register reference
    add_inst(16'h7800, 16'h0000, 1'b0, 1'b0, 1'b0, 4, R_AC, NONE, NONE, NONE);
    add_inst(16'h7400, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_CLE, NONE, NONE, NONE);
    add_inst(16'h7200, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_COM | L_AC, NONE, NONE, NONE);
    add_inst(16'h7100, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_CME, NONE, NONE, NONE);
    add_inst(16'h7080, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_SHR | L_AC, NONE, NONE, NONE);
    add_inst(16'h7040, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_SHL | L_AC, NONE, NONE, NONE);
    add_inst(16'h7020, 16'h0000, 1'b0, 1'b0, 1'b0, 4, I_AC, NONE, NONE, NONE);
    add_inst(16'h7010, 16'h8000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    add_inst(16'h7010, 16'h0001, 1'b0, 1'b0, 1'b0, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'h7008, 16'h8000, 1'b0, 1'b0, 1'b0, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'h7004, 16'h0000, 1'b0, 1'b0, 1'b0, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'h7004, 16'h0005, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    add_inst(16'h7002, 16'h0000, 1'b0, 1'b0, 1'b0, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'h7002, 16'h0000, 1'b1, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    add_inst(16'h7A00, 16'h0000, 1'b0, 1'b0, 1'b0, 4, R_AC, NONE, NONE, NONE);
    add_inst(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    add_inst(16'h7006, 16'h0000, 1'b1, 1'b0, 1'b0, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'h7003, 16'h0000, 1'b1, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    // input/output
    add_inst(16'hF800, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_INPR | L_AC, NONE, NONE, NONE);
    add_inst(16'hF400, 16'h0000, 1'b0, 1'b0, 1'b0, 4, S_AC | L_OUTR, NONE, NONE, NONE);
    add_inst(16'hF200, 16'h0000, 1'b0, 1'b0, 1'b1, 4, I_PC, NONE, NONE, NONE);
    add_inst(16'hF200, 16'h0000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    add_inst(16'hFC00, 16'h0000, 1'b0, 1'b0, 1'b0, 4, C_INPR | L_AC, NONE, NONE, NONE);
    add_inst(16'hF001, 16'h0000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    // HLT last: its T3 shows no strobe, halt begins on the following edge
    add_inst(16'h7001, 16'h0000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);

    // reset state
    @(negedge clk); #1;
    check("reset_sc", -1, {29'd0, sc}, 32'd0);
    check("reset_ctl", -1, pack_ctl(), NONE);
    @(negedge clk);
    RST_N = 1'b1;

    foreach (vq[k]) run_row(vq[k], k);

    // halted: SC frozen at 0, only the halted flag visible
    for (int c = 0; c < 12; c++) begin
      #1;
      check("halt_sc", 1000 + c, {29'd0, sc}, 32'd0);
      check("halt_ctl", 1000 + c, pack_ctl(), HALTED);
      @(negedge clk);
    end

    // reset clears halt immediately
    RST_N = 1'b0; #1;
    check("halt_reset_ctl", 2000, pack_ctl(), NONE);
    @(negedge clk);
    RST_N = 1'b1; #1;
    check("restart_ctl", 2001, pack_ctl(), F0);
    @(negedge clk);
    // finish that fetch as a NOP so the ISZ starts cleanly at T0
    vq.delete();
    add_inst(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b0, 4, NONE, NONE, NONE, NONE);
    for (int k = 1; k < 4; k++) run_row(vq[k], 2100 + k);

    // ISZ interrupted by reset during T5
    vq.delete();
    add_inst(16'h6008, 16'h0000, 1'b0, 1'b1, 1'b0, 7, NONE, S_MEM | L_DR, I_DR, S_DR | WR | I_PC);
    for (int k = 0; k < 5; k++) run_row(vq[k], 3000 + k);
    out_IR = 16'h6008; Zero_DR = 1'b1;
    #1;
    check("isz_t5_ctl", 3005, pack_ctl(), I_DR);
    RST_N = 1'b0; #1;
    check("abort_sc", 3006, {29'd0, sc}, 32'd0);
    check("abort_ctl", 3006, pack_ctl(), NONE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("abort_hold_ctl", 3010 + c, pack_ctl(), NONE);
    end
    @(negedge clk);
    RST_N = 1'b1; #1;
    check("refetch_sc", 3020, {29'd0, sc}, 32'd0);
    check("refetch_ctl", 3020, pack_ctl(), F0);
    @(negedge clk); #1;
    check("refetch_t1_sc", 3021, {29'd0, sc}, 32'd1);
    check("refetch_t1_ctl", 3021, pack_ctl(), F1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit_team1.md
# control_unit_team1

Hardwired control unit for the team1 basic-computer datapath. It holds a 3-bit sequence counter, the indirect flag and a halt flag, and decodes the instruction opcode to drive every load, increment, clear, ALU-select, memory and bus-select strobe of the datapath. It samples datapath status (IR, AC, E, DR-zero, FGI) and sequences fetch, decode, indirect and execute one bus transfer per clock.

## Interface
- Parameters: none. Word width is fixed at 16 bits; address width is fixed at 12 bits.
- clk  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- out_IR  in  16  instruction register contents.
- out_AC  in  16  accumulator contents (sign/zero tests).
- out_E  in  1  carry/E flag.
- Zero_DR  in  1  high when DR == 0.
- FGI  in  1  input flag.
- S  out  3  bus select: 1=AR, 2=PC, 3=DR, 4=AC, 5=IR, 6=TR, 7=MEM, 0=none.
- LD_PC, LD_AR, LD_AC, LD_DR, LD_IR, LD_OUTR, LD_TR  out  1 each  register loads.
- INR_PC, INR_AR, INR_AC, INR_DR, INR_TR  out  1 each  increments.
- RST_PC, RST_AR, RST_AC, RST_DR, RST_TR  out  1 each  synchronous clears.
- AND, ADD, LDA, COM, SHL, SHR, INPR_C  out  1 each  ALU function selects (at most one high).
- CLE, CME  out  1 each  clear / complement E.
- Read, Write  out  1 each  memory strobes.
- halted  out  1  HLT executed.
- sc  out  3  current timing step T0..T6 (debug).

## Operation
- State: SC (0..6), I (indirect bit), HALT. Control outputs are combinational decodes of SC, out_IR, I, HALT and the status inputs. The datapath acts on them at the next clk edge.
- Read = 1 whenever S = 7. All unlisted outputs are 0 in each step.
- T0: S=2, LD_AR.
- T1: S=7, LD_IR, INR_PC.
- T2: S=5, LD_AR. I <= out_IR[15].
- D = out_IR[14:12]. D7 means D == 7.
- T3 when D7 and I=0 (register reference), by out_IR bit:
  - b11 CLA: RST_AC.
  - b10 CLE: CLE.
  - b9 CMA: COM + LD_AC.
  - b8 CME: CME.
  - b7 CIR: SHR + LD_AC.
  - b6 CIL: SHL + LD_AC.
  - b5 INC: INR_AC.
  - b4 SPA: INR_PC if AC[15]=0.
  - b3 SNA: INR_PC if AC[15]=1.
  - b2 SZA: INR_PC if AC=0.
  - b1 SZE: INR_PC if E=0.
  - b0 HLT: HALT <= 1.
  - If several bits are set, only the highest-numbered one acts. If none is set, the step is a NOP.
  - SC <= 0.
- T3 when D7 and I=1 (I/O):
  - b11 INP: INPR_C + LD_AC.
  - b10 OUT: S=4, LD_OUTR.
  - b9 SKI: INR_PC if FGI.
  - Same highest-bit priority applies; other bits are NOP.
  - SC <= 0.
- T3 when not D7: if I=1, S=7, LD_AR (indirect). Otherwise no action.
- Memory reference, from T4:
  - D0 AND / D1 ADD / D2 LDA:
    - T4: S=7, LD_DR.
    - T5: AND / ADD / LDA select + LD_AC. SC <= 0.
  - D3 STA: T4: S=4, Write. SC <= 0.
  - D4 BUN: T4: S=1, LD_PC. SC <= 0.
  - D5 BSA:
    - T4: S=2, Write, INR_AR.
    - T5: S=1, LD_PC. SC <= 0.
  - D6 ISZ:
    - T4: S=7, LD_DR.
    - T5: INR_DR.
    - T6: S=3, Write, and INR_PC if Zero_DR. SC <= 0.
- Otherwise SC increments each clock.

## Timing
- Reset (RST_N low, asynchronous): SC=0, I=0, HALT=0. Every output is 0 except the decode of T0 once reset releases. While RST_N is low, all strobes are forced to 0.
- First post-reset edge executes T0.
- Instruction latency: register-reference / I/O 4 cycles; STA/BUN 5; AND/ADD/LDA/BSA 6; ISZ 7; each indirect-capable memory reference adds no cycle (T3 is always spent).
- HALT = 1: SC frozen, all strobes 0, halted = 1 until RST_N. HALT takes effect on the edge ending the HLT T3.
- Reset mid-instruction aborts immediately. No partial write occurs after assertion. The next fetch starts at T0.
- SC never exceeds 6. An illegal SC value forces SC <= 0 on the next edge.
- ISZ: DR 0xFFFF increments to 0x0000 (wrap). Zero_DR is sampled in T6, after the increment.

## Test plan
- Reset then fetch at PC=0, M[0]=0x2005 (LDA 5), M[5]=0x1234 -> AC=0x1234 and PC=1 after 6 cycles; S sequence 2,7,5,0,7,0.
- Indirect ADD 0x9006, M[6]=0x0010, M[0x10]=3, AC=4 -> T3 asserts S=7/LD_AR; AC=7 at end of T5.
- ISZ 0x6008 with M[8]=0xFFFF -> M[8]=0x0000 written in T6, INR_PC high, PC advanced by 2 total.
- BSA 0x500A at PC=0 -> M[0xA]=1, PC=0x00B after 6 cycles.
- SZA 0x7004 with AC=0 -> INR_PC at T3; HLT 0x7001 -> halted=1, all strobes 0 for 10+ cycles, SC frozen.
- RST_N pulsed low during ISZ T5 -> outputs 0 immediately, Write never asserted, fetch restarts at T0 after release.
